// File: rtl/alu_retire.sv
// alu_retire -- writeback/retire stage behind a single-issue execute stage.
//
// Takes one op per accepted cycle from execute and retires it:
//   kind 0 : ALU result written to the register file one cycle later
//   kind 1 : branch; when taken, pulses a fetch redirect and squashes the
//            next accepted op (the wrong-path instruction)
//   kind 2 : load; issues a memory request and stalls until acknowledged,
//            then writes the returned data one cycle after the ack
//   kind 3 : store/nop; retires with no visible activity
// Writes to r0 are always suppressed, but the op still counts as retired.
//
// Handshake: an op transfers on a rising edge where valid_i = 1 and
// ready_o = 1. ready_o depends only on the FSM state (low in LOAD_WAIT),
// never on valid_i, so execute may hold valid_i without risk of a loop.
// mem_req_o is held high, with mem_addr_o stable, until a cycle with
// mem_ack_i = 1; mem_rdata_i is taken in that same cycle.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_i / ready_o   op handshake from execute
//   kind_i, result_i, jump_now_i, rd_addr_i, br_target_i   op payload
//   rf_wen_o, rf_waddr_o, rf_wdata_o                       register write
//   mem_req_o, mem_addr_o, mem_ack_i, mem_rdata_i          load port
//   redirect_o, redirect_pc_o                              fetch redirect
//   retired_cnt_o, taken_cnt_o   (only with ALU_RETIRE_PERF_EN defined)
//
// Optional feature: define ALU_RETIRE_PERF_EN to add the retired-op and
// taken-redirect counters. The default build leaves them out.
// The FSM state is held in 'state' (type state_t) for observation.

module alu_retire (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  kind_i,
  input  logic [31:0] result_i,
  input  logic        jump_now_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] br_target_i,
  output logic        rf_wen_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
`ifdef ALU_RETIRE_PERF_EN
  ,
  output logic [31:0] retired_cnt_o,
  output logic [31:0] taken_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    SQUASH    = 2'd2
  } state_t;

  localparam logic [1:0] KIND_ALU    = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_LOAD   = 2'd2;
  localparam logic [1:0] KIND_NOWR   = 2'd3;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  ld_rd;
  logic [4:0]  ld_rd_nxt;
  logic        accept;

  logic        wen_nxt;
  logic [4:0]  waddr_nxt;
  logic [31:0] wdata_nxt;
  logic        mem_req_nxt;
  logic [31:0] mem_addr_nxt;
  logic        redir_nxt;
  logic [31:0] redir_pc_nxt;
  logic        retire;
  logic        taken;

  assign ready_o = (state != LOAD_WAIT);
  assign accept  = valid_i & ready_o;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and next registered outputs. Data outputs default to their
  // current value so they hold while their strobe is low.
  always_comb begin
    state_nxt    = state;
    ld_rd_nxt    = ld_rd;
    wen_nxt      = 1'b0;
    waddr_nxt    = rf_waddr_o;
    wdata_nxt    = rf_wdata_o;
    mem_addr_nxt = mem_addr_o;
    redir_nxt    = 1'b0;
    redir_pc_nxt = redirect_pc_o;
    retire       = 1'b0;
    taken        = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (kind_i)
            KIND_ALU: begin
              retire = 1'b1;
              if (rd_addr_i != 5'd0) begin
                wen_nxt   = 1'b1;
                waddr_nxt = rd_addr_i;
                wdata_nxt = result_i;
              end
            end
            KIND_BRANCH: begin
              retire = 1'b1;
              // jump_now_i is only looked at here, so an unknown value on
              // any other kind cannot reach the outputs.
              if (jump_now_i) begin
                taken        = 1'b1;
                redir_nxt    = 1'b1;
                redir_pc_nxt = br_target_i;
                state_nxt    = SQUASH;
              end
            end
            KIND_LOAD: begin
              mem_addr_nxt = result_i;
              ld_rd_nxt    = rd_addr_i;
              state_nxt    = LOAD_WAIT;
            end
            KIND_NOWR: begin
              retire = 1'b1;
            end
            default: ;
          endcase
        end
      end
      LOAD_WAIT: begin
        if (mem_ack_i) begin
          retire    = 1'b1;
          state_nxt = IDLE;
          if (ld_rd != 5'd0) begin
            wen_nxt   = 1'b1;
            waddr_nxt = ld_rd;
            wdata_nxt = mem_rdata_i;
          end
        end
      end
      SQUASH: begin
        // The wrong-path op is consumed and dropped without side effects.
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    mem_req_nxt = (state_nxt == LOAD_WAIT);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_rd         <= 5'd0;
      rf_wen_o      <= 1'b0;
      rf_waddr_o    <= 5'd0;
      rf_wdata_o    <= 32'd0;
      mem_req_o     <= 1'b0;
      mem_addr_o    <= 32'd0;
      redirect_o    <= 1'b0;
      redirect_pc_o <= 32'd0;
    end else begin
      ld_rd         <= ld_rd_nxt;
      rf_wen_o      <= wen_nxt;
      rf_waddr_o    <= waddr_nxt;
      rf_wdata_o    <= wdata_nxt;
      mem_req_o     <= mem_req_nxt;
      mem_addr_o    <= mem_addr_nxt;
      redirect_o    <= redir_nxt;
      redirect_pc_o <= redir_pc_nxt;
    end
  end

`ifdef ALU_RETIRE_PERF_EN
  // Free-running counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt_o <= 32'd0;
      taken_cnt_o   <= 32'd0;
    end else begin
      if (retire) retired_cnt_o <= retired_cnt_o + 32'd1;
      if (taken)  taken_cnt_o   <= taken_cnt_o + 32'd1;
    end
  end
`else
  // Without the counters these decodes have no consumer.
  logic unused_perf;
  assign unused_perf = retire ^ taken;
`endif

endmodule

// File: tb/tb_alu_retire.sv
// tb_alu_retire -- directed bench for alu_retire.
// Inputs change 1 time unit after a rising edge; outputs are looked at in the
// same place, i.e. the value registered by the edge just passed.
// Every register-file write is matched against a queue of expected writes.

module tb_alu_retire;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  kind_i;
  logic [31:0] result_i;
  logic        jump_now_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] br_target_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
`ifdef ALU_RETIRE_PERF_EN
  logic [31:0] retired_cnt_o;
  logic [31:0] taken_cnt_o;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // {addr, data} of each register write that should appear, in order
  logic [36:0] exp_q[$];

  alu_retire dut (
    .clk           (clk),
    .reset         (reset),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .kind_i        (kind_i),
    .result_i      (result_i),
    .jump_now_i    (jump_now_i),
    .rd_addr_i     (rd_addr_i),
    .br_target_i   (br_target_i),
    .rf_wen_o      (rf_wen_o),
    .rf_waddr_o    (rf_waddr_o),
    .rf_wdata_o    (rf_wdata_o),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o)
`ifdef ALU_RETIRE_PERF_EN
    ,
    .retired_cnt_o (retired_cnt_o),
    .taken_cnt_o   (taken_cnt_o)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for one cycle; returns 1 time unit after the edge that
  // accepted it, so outputs then show the cycle after acceptance.
  task automatic send(input logic [1:0] kind, input logic [31:0] res, input logic jmp,
                      input logic [4:0] rd, input logic [31:0] tgt);
    valid_i     = 1'b1;
    kind_i      = kind;
    result_i    = res;
    jump_now_i  = jmp;
    rd_addr_i   = rd;
    br_target_i = tgt;
    tick();
    valid_i     = 1'b0;
    jump_now_i  = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the head of the queue.
  always @(negedge clk) begin
    if (rf_wen_o) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected_addr", 64'(rf_waddr_o), 64'd0);
      end else begin
        check("wr_scoreboard", 64'({rf_waddr_o, rf_wdata_o}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset       = 1'b1;
    valid_i     = 1'b0;
    kind_i      = 2'd0;
    result_i    = 32'd0;
    jump_now_i  = 1'b0;
    rd_addr_i   = 5'd0;
    br_target_i = 32'd0;
    mem_ack_i   = 1'b0;
    mem_rdata_i = 32'd0;
    repeat (2) tick();

    // Reset values
    check("rst_wen",      64'(rf_wen_o),      64'd0);
    check("rst_mem_req",  64'(mem_req_o),     64'd0);
    check("rst_redirect", 64'(redirect_o),    64'd0);
    check("rst_waddr",    64'(rf_waddr_o),    64'd0);
    check("rst_wdata",    64'(rf_wdata_o),    64'd0);
    check("rst_mem_addr", 64'(mem_addr_o),    64'd0);
    check("rst_redir_pc", 64'(redirect_pc_o), 64'd0);
    reset = 1'b0;
    tick();
    check("rst_ready", 64'(ready_o), 64'd1);
`ifdef ALU_RETIRE_PERF_EN
    check("rst_retired", 64'(retired_cnt_o), 64'd0);
    check("rst_taken",   64'(taken_cnt_o),   64'd0);
`endif

    // ALU write r5 = 7, one-cycle strobe
    exp_q.push_back({5'd5, 32'h7});
    send(2'd0, 32'h7, 1'b0, 5'd5, 32'h0);
    check("alu_wen",   64'(rf_wen_o),   64'd1);
    check("alu_waddr", 64'(rf_waddr_o), 64'd5);
    check("alu_wdata", 64'(rf_wdata_o), 64'h7);
    tick();
    check("alu_wen_drop", 64'(rf_wen_o), 64'd0);

    // Write to r0 suppressed, data outputs hold the last write
    send(2'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0);
    check("r0_wen",        64'(rf_wen_o),   64'd0);
    check("r0_waddr_hold", 64'(rf_waddr_o), 64'd5);
    check("r0_wdata_hold", 64'(rf_wdata_o), 64'h7);
`ifdef ALU_RETIRE_PERF_EN
    check("r0_retired", 64'(retired_cnt_o), 64'd2);
`endif

    // Idle-time ack is ignored
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h1234;
    tick();
    mem_ack_i   = 1'b0;
    check("stray_ack_wen", 64'(rf_wen_o),  64'd0);
    check("stray_ack_req", 64'(mem_req_o), 64'd0);

    // Taken branch, next op (kind 0 r3) squashed immediately
    send(2'd1, 32'h0, 1'b1, 5'd0, 32'h40);
    check("br_redirect", 64'(redirect_o),    64'd1);
    check("br_pc",       64'(redirect_pc_o), 64'h40);
    check("br_ready",    64'(ready_o),       64'd1);
    check("br_wen",      64'(rf_wen_o),      64'd0);
`ifdef ALU_RETIRE_PERF_EN
    check("br_retired", 64'(retired_cnt_o), 64'd3);
    check("br_taken",   64'(taken_cnt_o),   64'd1);
`endif
    send(2'd0, 32'h33, 1'b0, 5'd3, 32'h0);
    check("sq_redirect_once", 64'(redirect_o),    64'd0);
    check("sq_wen",           64'(rf_wen_o),      64'd0);
    check("sq_pc_hold",       64'(redirect_pc_o), 64'h40);
    // Back in IDLE: next op writes normally
    exp_q.push_back({5'd4, 32'h44});
    send(2'd0, 32'h44, 1'b0, 5'd4, 32'h0);
    check("post_sq_wen",   64'(rf_wen_o),   64'd1);
    check("post_sq_waddr", 64'(rf_waddr_o), 64'd4);

    // Taken branch, idle cycles stay in SQUASH, then a squashed branch
    send(2'd1, 32'h0, 1'b1, 5'd0, 32'h80);
    check("br2_pc", 64'(redirect_pc_o), 64'h80);
    repeat (2) tick();
    send(2'd1, 32'h0, 1'b1, 5'd6, 32'hC0);
    check("sq2_redirect", 64'(redirect_o),    64'd0);
    check("sq2_pc_hold",  64'(redirect_pc_o), 64'h80);
    exp_q.push_back({5'd6, 32'h66});
    send(2'd0, 32'h66, 1'b0, 5'd6, 32'h0);
    check("post_sq2_wen", 64'(rf_wen_o), 64'd1);

    // Not-taken branch: nothing happens and no squash follows
    send(2'd1, 32'h0, 1'b0, 5'd0, 32'h100);
    check("nt_redirect", 64'(redirect_o), 64'd0);
    check("nt_wen",      64'(rf_wen_o),   64'd0);
    exp_q.push_back({5'd7, 32'h77});
    send(2'd0, 32'h77, 1'b0, 5'd7, 32'h0);
    check("post_nt_wen", 64'(rf_wen_o), 64'd1);

    // Load r9 from 0x100, ack in the third request cycle
    send(2'd2, 32'h100, 1'b0, 5'd9, 32'h0);
    check("ld_c1_req",   64'(mem_req_o),  64'd1);
    check("ld_c1_ready", 64'(ready_o),    64'd0);
    check("ld_c1_addr",  64'(mem_addr_o), 64'h100);
    tick();
    check("ld_c2_req",   64'(mem_req_o),  64'd1);
    check("ld_c2_ready", 64'(ready_o),    64'd0);
    tick();
    check("ld_c3_req",   64'(mem_req_o),  64'd1);
    check("ld_c3_ready", 64'(ready_o),    64'd0);
    check("ld_c3_addr",  64'(mem_addr_o), 64'h100);
    // Ack plus an op that must not be accepted while stalled
    exp_q.push_back({5'd9, 32'hDEAD_BEEF});
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    valid_i     = 1'b1;
    kind_i      = 2'd0;
    rd_addr_i   = 5'd2;
    result_i    = 32'h22;
    tick();
    mem_ack_i   = 1'b0;
    valid_i     = 1'b0;
    check("ld_wen",   64'(rf_wen_o),   64'd1);
    check("ld_waddr", 64'(rf_waddr_o), 64'd9);
    check("ld_wdata", 64'(rf_wdata_o), 64'hDEAD_BEEF);
    check("ld_req0",  64'(mem_req_o),  64'd0);
    check("ld_ready", 64'(ready_o),    64'd1);
    tick();
    check("ld_stall_op_dropped", 64'(rf_wen_o), 64'd0);

    // Load into r0: completes without a write
    send(2'd2, 32'h200, 1'b0, 5'd0, 32'h0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'h5555;
    tick();
    mem_ack_i   = 1'b0;
    check("ld_r0_wen",   64'(rf_wen_o), 64'd0);
    check("ld_r0_ready", 64'(ready_o),  64'd1);

    // Reset in cycle 2 of LOAD_WAIT, together with ack and a valid op
    send(2'd2, 32'h300, 1'b0, 5'd10, 32'h0);
    tick();
    reset       = 1'b1;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hBAD0;
    valid_i     = 1'b1;
    kind_i      = 2'd0;
    rd_addr_i   = 5'd1;
    result_i    = 32'h11;
    tick();
    reset       = 1'b0;
    valid_i     = 1'b0;
    check("rl_req",   64'(mem_req_o),  64'd0);
    check("rl_wen",   64'(rf_wen_o),   64'd0);
    check("rl_ready", 64'(ready_o),    64'd1);
    check("rl_wdata", 64'(rf_wdata_o), 64'd0);
    // Late ack after reset is ignored
    tick();
    mem_ack_i = 1'b0;
    check("rl_late_wen", 64'(rf_wen_o),  64'd0);
    check("rl_late_req", 64'(mem_req_o), 64'd0);
`ifdef ALU_RETIRE_PERF_EN
    check("rl_retired", 64'(retired_cnt_o), 64'd0);
    check("rl_taken",   64'(taken_cnt_o),   64'd0);
`endif

    // Unknown jump_now_i on non-branch ops is ignored
    exp_q.push_back({5'd11, 32'hB});
    send(2'd0, 32'hB, 1'bx, 5'd11, 32'h500);
    check("xj_wen",      64'(rf_wen_o),   64'd1);
    check("xj_waddr",    64'(rf_waddr_o), 64'd11);
    check("xj_redirect", 64'(redirect_o), 64'd0);
    send(2'd3, 32'h55, 1'bx, 5'd12, 32'h600);
    check("xj_k3_redirect", 64'(redirect_o), 64'd0);

    // kind 3 with jump high: no activity, not followed by a squash
    send(2'd3, 32'h55, 1'b1, 5'd12, 32'h90);
    check("k3_wen",      64'(rf_wen_o),   64'd0);
    check("k3_redirect", 64'(redirect_o), 64'd0);
    check("k3_req",      64'(mem_req_o),  64'd0);
    exp_q.push_back({5'd13, 32'hD});
    send(2'd0, 32'hD, 1'b0, 5'd13, 32'h0);
    check("post_k3_wen", 64'(rf_wen_o), 64'd1);
    tick();
`ifdef ALU_RETIRE_PERF_EN
    check("end_retired", 64'(retired_cnt_o), 64'd4);
    check("end_taken",   64'(taken_cnt_o),   64'd0);
`endif

    tick();
    check("wr_outstanding", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
